orange_region_tracker: RTL and testbench
========================================

# orange_region_tracker

Frame-level orange localiser sitting directly downstream of `target_finder` on the 25 MHz VGA pixel clock. It consumes the per-pixel `is_orange` flag together with the VGA `activeArea` and `vSync` timing. It accumulates orange-pixel counts in left/middle/right thirds of each frame and, at each frame boundary, publishes a detection flag, a total count and a hysteresis-filtered direction for `FSM`.

## Interface

Parameters:
- `H_ACTIVE`, 640: active pixels per line.
- `COUNT_W`, 19: width of region and total counters, saturating.
- `DETECT_THRESH`, 2000: minimum total orange pixels per frame for detection.
- `HYST_FRAMES`, 3: consecutive identical frame decisions required before `direction` changes (≥1).

Ports:
- `clk`, input, 1: pixel clock (`clk_25_vga`).
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `active`, input, 1: VGA active-area qualifier (`activeArea`).
- `vsync`, input, 1: VGA vertical sync, active-low.
- `is_orange`, input, 1: current pixel passed orange threshold; valid only when `active`=1.
- `orange_detected`, output, 1: last completed frame total ≥ `DETECT_THRESH`.
- `direction`, output, 3: filtered one-hot direction. 100 = left, 010 = middle, 001 = right, 000 = none.
- `orange_count`, output, `COUNT_W`: last completed frame total, saturated.
- `frame_valid`, output, 1: one-cycle pulse when the outputs above update.

## Operation

- Column counter `x`:
  - Increments on every cycle with `active`=1.
  - Clears on any cycle with `active`=0.
  - Saturates at `H_ACTIVE-1` if `active` persists.
- Region of the current pixel, from `x` (elaboration constants):
  - `x < H_ACTIVE/3` → left.
  - `x < 2*H_ACTIVE/3` → middle.
  - Otherwise right.
  - For 640: left 0–212, middle 213–425, right 426–639.
- On `active & is_orange`, the region counter increments. Counters saturate at 2^`COUNT_W`−1; they never wrap.
- Frame end: `vsync` falling edge.
  - `vsync_q` is `vsync` registered.
  - `frame_end = vsync_q & ~vsync`.
- On a `frame_end` cycle:
  - `total` = L+M+R, computed `COUNT_W+2` bits wide, then saturated to `COUNT_W` bits.
  - `orange_count` ← `total`.
  - `orange_detected` ← (`total` ≥ `DETECT_THRESH`).
  - `frame_valid` ← 1.
  - Winner is the largest region count. Ties go to middle first, then left, then right.
  - `candidate` = winner one-hot if detected, else 000.
  - Hysteresis:
    - If `candidate == cand_prev`, `stable_cnt` increments, saturating at `HYST_FRAMES`.
    - Otherwise `cand_prev` ← `candidate` and `stable_cnt` ← 1.
    - If the post-update `stable_cnt` ≥ `HYST_FRAMES`, `direction` ← `candidate`; otherwise `direction` holds.
  - All three region counters clear.
- Simultaneous `frame_end` and a counted pixel: the pixel counts into the new frame (the counter loads 1, not 0). In practice it does not occur, because the VGA sync falls in blanking.
- Reset values (applied on any clock edge with `rst_n`=0, including mid-frame):
  - All counters 0, `x`=0, `vsync_q`=1.
  - `cand_prev`=000, `stable_cnt`=0.
  - `orange_detected`=0, `direction`=000, `orange_count`=0, `frame_valid`=0.
- A partial frame after reset is counted normally and is reported at the next `frame_end`.

## Timing

- The counting path is registered. A pixel sampled at edge *n* is reflected in its region counter after edge *n*.
- Frame-end latency: `vsync` low sampled at edge *n* (with `vsync_q`=1) → outputs and `frame_valid`=1 visible after edge *n*. `frame_valid` returns to 0 after edge *n+1*.
- `orange_detected`, `orange_count` and `direction` are stable for the whole following frame.
- Direction change latency: `HYST_FRAMES` consecutive frames with the same candidate. With `HYST_FRAMES`=1, `direction` follows each frame.
- `vsync` held low for many cycles produces exactly one `frame_end`. `vsync` held high produces none, and counters keep accumulating, saturating.

## Test plan

- **Left-only frame.** Three frames, each with 3000 orange pixels at x=0–99 → after frames 1 and 2, `orange_detected`=1, `orange_count`=3000, `direction`=000; after frame 3, `direction`=100.
- **Below threshold.** 1999 orange pixels in the middle region → `orange_detected`=0, candidate 000. After 3 such frames from any state, `direction`=000. At exactly 2000 pixels → `orange_detected`=1.
- **Region boundaries and ties.** Boundary pixels land in the middle (x=213) and right (x=426) regions. Equal counts of 1500 left, 1500 middle → middle wins; after 3 frames, `direction`=010.
- **Hysteresis break.** Candidate sequence R,R,L,R,R,R → `direction` becomes 001 only after the 6th frame. `frame_valid` pulses exactly once per frame for one cycle.
- **Reset mid-frame.** Apply `rst_n`=0 for 1 cycle during active video → all outputs 0 next cycle. The next `frame_end` reports only pixels counted after reset.
- **Saturation.** With `COUNT_W`=8, 300 orange pixels per region → `orange_count`=255, and no wrap in the region counters.

Source files
------------

// File: rtl/orange_region_tracker_if.sv
// Pixel-side inputs and per-frame results exchanged with the orange region tracker.
// The master drives the VGA qualifiers and receives the frame report. The slave is the tracker.
interface orange_region_tracker_if #(
  parameter int COUNT_W = 19
);
  logic               active;
  logic               vsync;
  logic               is_orange;
  logic               orange_detected;
  logic [2:0]         direction;
  logic [COUNT_W-1:0] orange_count;
  logic               frame_valid;

  modport master (
    output active, vsync, is_orange,
    input  orange_detected, direction, orange_count, frame_valid
  );

  modport slave (
    input  active, vsync, is_orange,
    output orange_detected, direction, orange_count, frame_valid
  );
endinterface

// File: rtl/orange_region_tracker.sv
// Counts orange pixels in left/middle/right thirds and reports a hysteresis-filtered direction per frame.
// Frame report is registered one cycle after the sampled vsync fall. There is no backpressure: pixels are consumed every clock.
module orange_region_tracker #(
  parameter int H_ACTIVE      = 640,
  parameter int COUNT_W       = 19,
  parameter int DETECT_THRESH = 2000,
  parameter int HYST_FRAMES   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  orange_region_tracker_if.slave bus
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int SW = $clog2(HYST_FRAMES + 1);
  localparam int TW = COUNT_W + 2;
  localparam logic [XW-1:0] X_MAX    = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] LEFT_END = XW'(H_ACTIVE / 3);
  localparam logic [XW-1:0] MID_END  = XW'(2 * H_ACTIVE / 3);
  localparam logic [SW-1:0] HYST_C   = SW'(HYST_FRAMES);
  localparam logic [TW-1:0] THRESH_C = TW'(DETECT_THRESH);

  logic [XW-1:0]      x_q, x_d;
  logic [COUNT_W-1:0] cnt_l_q, cnt_l_d, cnt_m_q, cnt_m_d, cnt_r_q, cnt_r_d;
  logic               vsync_q;
  logic [2:0]         cand_prev_q, cand_prev_d;
  logic [SW-1:0]      stable_q, stable_d;
  logic               det_q, det_d;
  logic [2:0]         dir_q, dir_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               fv_q;

  logic               frame_end, pix, in_l, in_m;
  logic [TW-1:0]      total;
  logic [COUNT_W-1:0] total_sat;
  logic               detected;
  logic [2:0]         winner, candidate;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  assign frame_end = vsync_q & ~bus.vsync;
  assign pix       = bus.active & bus.is_orange;
  assign in_l      = x_q < LEFT_END;
  assign in_m      = ~in_l & (x_q < MID_END);

  always_comb begin
    x_d = '0;
    if (bus.active) x_d = (x_q == X_MAX) ? x_q : x_q + XW'(1);
  end

  // A pixel coinciding with frame_end starts the new frame's count at 1.
  always_comb begin
    cnt_l_d = frame_end ? '0 : cnt_l_q;
    cnt_m_d = frame_end ? '0 : cnt_m_q;
    cnt_r_d = frame_end ? '0 : cnt_r_q;
    if (pix && in_l)             cnt_l_d = sat_inc(cnt_l_d);
    if (pix && in_m)             cnt_m_d = sat_inc(cnt_m_d);
    if (pix && !in_l && !in_m)   cnt_r_d = sat_inc(cnt_r_d);
  end

  always_comb begin
    total     = {2'b00, cnt_l_q} + {2'b00, cnt_m_q} + {2'b00, cnt_r_q};
    total_sat = (|total[TW-1:COUNT_W]) ? '1 : total[COUNT_W-1:0];
    detected  = total >= THRESH_C;
    if (cnt_m_q >= cnt_l_q && cnt_m_q >= cnt_r_q) winner = 3'b010;
    else if (cnt_l_q >= cnt_r_q)                   winner = 3'b100;
    else                                           winner = 3'b001;
    candidate = detected ? winner : 3'b000;
  end

  // Direction only moves once the same candidate has been seen HYST_FRAMES frames in a row.
  always_comb begin
    cand_prev_d = cand_prev_q;
    stable_d    = stable_q;
    det_d       = det_q;
    count_d     = count_q;
    dir_d       = dir_q;
    if (frame_end) begin
      det_d   = detected;
      count_d = total_sat;
      if (candidate == cand_prev_q) begin
        stable_d = (stable_q >= HYST_C) ? HYST_C : stable_q + SW'(1);
      end else begin
        cand_prev_d = candidate;
        stable_d    = SW'(1);
      end
      if (stable_d >= HYST_C) dir_d = candidate;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= '0;
      cnt_l_q     <= '0;
      cnt_m_q     <= '0;
      cnt_r_q     <= '0;
      vsync_q     <= 1'b1;
      cand_prev_q <= 3'b000;
      stable_q    <= '0;
      det_q       <= 1'b0;
      dir_q       <= 3'b000;
      count_q     <= '0;
      fv_q        <= 1'b0;
    end else begin
      x_q         <= x_d;
      cnt_l_q     <= cnt_l_d;
      cnt_m_q     <= cnt_m_d;
      cnt_r_q     <= cnt_r_d;
      vsync_q     <= bus.vsync;
      cand_prev_q <= cand_prev_d;
      stable_q    <= stable_d;
      det_q       <= det_d;
      dir_q       <= dir_d;
      count_q     <= count_d;
      fv_q        <= frame_end;
    end
  end

  assign bus.orange_detected = det_q;
  assign bus.direction       = dir_q;
  assign bus.orange_count    = count_q;
  assign bus.frame_valid     = fv_q;
endmodule

// File: tb/tb_orange_region_tracker.sv
// Directed bench: a default tracker plus a narrow (COUNT_W=8, threshold 1, no hysteresis) instance on shared stimulus.
module tb_orange_region_tracker;
  logic clk = 1'b0;
  logic rst_n;
  logic active, vsync, is_orange;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_frames = 0;
  int   fv_pulses = 0;

  always #20 clk = ~clk;

  orange_region_tracker_if #(.COUNT_W(19)) bus1 ();
  orange_region_tracker_if #(.COUNT_W(8))  bus2 ();

  assign bus1.active = active;  assign bus1.vsync = vsync;  assign bus1.is_orange = is_orange;
  assign bus2.active = active;  assign bus2.vsync = vsync;  assign bus2.is_orange = is_orange;

  orange_region_tracker dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  orange_region_tracker #(.H_ACTIVE(640), .COUNT_W(8), .DETECT_THRESH(1), .HYST_FRAMES(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always @(negedge clk) if (bus1.frame_valid === 1'b1) fv_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // reps lines of len active cycles; orange where lo <= pixel index <= hi.
  task automatic run(input int reps, input int len, input int lo, input int hi);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < len; i++) begin
        active = 1'b1;
        is_orange = (i >= lo && i <= hi);
        @(negedge clk);
      end
      active = 1'b0;
      is_orange = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic end_frame(input string tag, input logic det, input int cnt, input logic [2:0] dir);
    vsync = 1'b0;
    @(negedge clk);
    n_frames++;
    chk({tag, ".fv"},  bus1.frame_valid, 1);
    chk({tag, ".det"}, bus1.orange_detected, det);
    chk({tag, ".cnt"}, bus1.orange_count, cnt);
    chk({tag, ".dir"}, bus1.direction, dir);
    @(negedge clk);
    chk({tag, ".fv_drop"}, bus1.frame_valid, 0);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; active = 1'b0; vsync = 1'b1; is_orange = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.det", bus1.orange_detected, 0);
    chk("rst.dir", bus1.direction, 3'b000);
    chk("rst.cnt", bus1.orange_count, 0);
    chk("rst.fv",  bus1.frame_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Left-only: 3000 pixels at x=0..99, direction needs three frames
    run(30, 100, 0, 99); end_frame("left1", 1, 3000, 3'b000);
    run(30, 100, 0, 99); end_frame("left2", 1, 3000, 3'b000);
    run(30, 100, 0, 99); end_frame("left3", 1, 3000, 3'b100);

    // Below threshold: 1999 middle pixels
    run(9, 426, 213, 425); run(1, 295, 213, 294); end_frame("low1", 0, 1999, 3'b100);
    run(9, 426, 213, 425); run(1, 295, 213, 294); end_frame("low2", 0, 1999, 3'b100);
    run(9, 426, 213, 425); run(1, 295, 213, 294); end_frame("low3", 0, 1999, 3'b000);
    run(9, 426, 213, 425); run(1, 296, 213, 295); end_frame("thr2000", 1, 2000, 3'b000);

    // Tie 1500 left / 1500 middle -> middle
    for (int f = 0; f < 3; f++) begin
      run(7, 213, 0, 212); run(1, 9, 0, 8);
      run(7, 426, 213, 425); run(1, 222, 213, 221);
      end_frame($sformatf("tie%0d", f + 1), 1, 3000, (f == 1) ? 3'b010 : (f == 0 ? 3'b000 : 3'b010));
    end

    // Hysteresis break R,R,L,R,R,R; right pixels use x held at 639 past the line end
    run(1, 2526, 426, 100000); end_frame("hyR1", 1, 2100, 3'b010);
    run(1, 2526, 426, 100000); end_frame("hyR2", 1, 2100, 3'b010);
    run(21, 100, 0, 99);       end_frame("hyL3", 1, 2100, 3'b010);
    run(1, 2526, 426, 100000); end_frame("hyR4", 1, 2100, 3'b010);
    run(1, 2526, 426, 100000); end_frame("hyR5", 1, 2100, 3'b010);
    run(1, 2526, 426, 100000); end_frame("hyR6", 1, 2100, 3'b001);

    // Reset during active video discards the partial frame
    run(10, 100, 0, 99);
    active = 1'b1; is_orange = 1'b1;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst.det", bus1.orange_detected, 0);
    chk("mrst.dir", bus1.direction, 3'b000);
    chk("mrst.cnt", bus1.orange_count, 0);
    chk("mrst.fv",  bus1.frame_valid, 0);
    chk("mrst.cnt2", bus2.orange_count, 0);
    rst_n = 1'b1; active = 1'b0; is_orange = 1'b0;
    repeat (2) @(negedge clk);
    run(21, 100, 0, 99); end_frame("after_rst", 1, 2100, 3'b000);
    chk("after_rst.cnt2", bus2.orange_count, 255);
    chk("after_rst.dir2", bus2.direction, 3'b100);

    // Region boundaries on the threshold-1 instance
    run(1, 214, 213, 213); end_frame("b213", 0, 1, 3'b000);
    chk("b213.dir2", bus2.direction, 3'b010);
    run(1, 213, 212, 212); end_frame("b212", 0, 1, 3'b000);
    chk("b212.dir2", bus2.direction, 3'b100);
    run(1, 426, 425, 425); end_frame("b425", 0, 1, 3'b000);
    chk("b425.dir2", bus2.direction, 3'b010);
    run(1, 427, 426, 426); end_frame("b426", 0, 1, 3'b000);
    chk("b426.dir2", bus2.direction, 3'b001);
    chk("b426.det2", bus2.orange_detected, 1);

    // Saturation with COUNT_W=8: 300 per region
    run(2, 150, 0, 149); run(2, 363, 213, 362); run(1, 726, 426, 100000);
    end_frame("sat", 0, 900, 3'b000);
    chk("sat.cnt2", bus2.orange_count, 255);
    chk("sat.dir2", bus2.direction, 3'b010);
    // 300 left vs 200 middle: a wrapped left counter would lose to middle
    run(2, 150, 0, 149); run(1, 413, 213, 412);
    end_frame("nowrap", 0, 500, 3'b000);
    chk("nowrap.cnt2", bus2.orange_count, 255);
    chk("nowrap.dir2", bus2.direction, 3'b100);

    chk("fv_pulses", fv_pulses, n_frames);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
